// File: rtl/seg_scan_pkg.sv
// Shared types and polarity helpers for the
// two-digit multiplexed 7-segment scanner.
package seg_scan_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLANK0 = 3'd1,
    SHOW0  = 3'd2,
    BLANK1 = 3'd3,
    SHOW1  = 3'd4
  } state_e;

  // Logical (active-high) patterns before polarity.
  localparam logic [SEG_W-1:0] SEG_NONE = '0;
  localparam logic [DIG_W-1:0] DIG_NONE = 2'b00;
  localparam logic [DIG_W-1:0] DIG_D0   = 2'b01;
  localparam logic [DIG_W-1:0] DIG_D1   = 2'b10;

  function automatic logic [SEG_W-1:0] seg_drive(
    input logic             act_low,
    input logic [SEG_W-1:0] pat
  );
    return act_low ? ~pat : pat;
  endfunction

  function automatic logic [DIG_W-1:0] dig_drive(
    input logic             act_low,
    input logic [DIG_W-1:0] pat
  );
    return act_low ? ~pat : pat;
  endfunction

  function automatic logic [SEG_W-1:0] seg_off(
    input logic act_low
  );
    return seg_drive(act_low, SEG_NONE);
  endfunction

  function automatic logic [DIG_W-1:0] dig_off(
    input logic act_low
  );
    return dig_drive(act_low, DIG_NONE);
  endfunction

endpackage

// File: rtl/seg_phase_counter.sv
// Phase counter: clears on request, counts up and
// holds at the terminal value so it never wraps.
module seg_phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_len_m1,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  assign w_tc = (r_cnt == i_len_m1);
  assign o_tc = w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!w_tc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit 7-segment scan driver with blanking
// between digits and a per-frame input snapshot.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SHOW_CYCLES    = 50000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEG_W-1:0] seg1_in,
  input  logic [SEG_W-1:0] seg2_in,
  output logic [SEG_W-1:0] seg_out,
  output logic [DIG_W-1:0] dig_en,
  output logic             frame_pulse
);

  localparam int MAXC =
    (SHOW_CYCLES > BLANK_CYCLES) ?
    SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SHOW_M1 =
    CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_M1 =
    CW'(BLANK_CYCLES - 1);

  localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_AL = (DIG_ACTIVE_LOW != 0);

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    w_len_m1;
  logic             w_tc;
  logic             w_clr;
  logic             w_load;

  logic [SEG_W-1:0] r_snap0;
  logic [SEG_W-1:0] r_snap1;
  logic [SEG_W-1:0] r_seg;
  logic [DIG_W-1:0] r_dig;
  logic             r_fp;

  logic [SEG_W-1:0] w_seg_d;
  logic [DIG_W-1:0] w_dig_d;
  logic             w_fp_d;

  always_comb begin
    w_len_m1 = '0;
    unique case (r_state)
      BLANK0, BLANK1: w_len_m1 = BLANK_M1;
      SHOW0, SHOW1:   w_len_m1 = SHOW_M1;
      default:        w_len_m1 = '0;
    endcase
  end

  seg_phase_counter #(
    .W (CW)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_len_m1 (w_len_m1),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dropping en wins over any phase expiry.
  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_next = BLANK0;
        BLANK0:  if (w_tc) w_next = SHOW0;
        SHOW0:   if (w_tc) w_next = BLANK1;
        BLANK1:  if (w_tc) w_next = SHOW1;
        SHOW1:   if (w_tc) w_next = BLANK0;
        default: w_next = IDLE;
      endcase
    end
  end

  assign w_clr  = (w_next != r_state) ||
                  (w_next == IDLE);
  assign w_load = (w_next == BLANK0) &&
                  (r_state != BLANK0);

  // Outputs decode the state being entered.
  always_comb begin
    w_seg_d = seg_off(SEG_AL);
    w_dig_d = dig_off(DIG_AL);
    w_fp_d  = (w_next == BLANK0) &&
              (r_state == SHOW1);
    unique case (w_next)
      SHOW0: begin
        w_seg_d = seg_drive(SEG_AL, r_snap0);
        w_dig_d = dig_drive(DIG_AL, DIG_D0);
      end
      SHOW1: begin
        w_seg_d = seg_drive(SEG_AL, r_snap1);
        w_dig_d = dig_drive(DIG_AL, DIG_D1);
      end
      default: begin
        w_seg_d = seg_off(SEG_AL);
        w_dig_d = dig_off(DIG_AL);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap0 <= '0;
      r_snap1 <= '0;
    end else if (w_load) begin
      r_snap0 <= seg1_in;
      r_snap1 <= seg2_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= seg_off(SEG_AL);
      r_dig <= dig_off(DIG_AL);
      r_fp  <= 1'b0;
    end else begin
      r_seg <= w_seg_d;
      r_dig <= w_dig_d;
      r_fp  <= w_fp_d;
    end
  end

  assign seg_out     = r_seg;
  assign dig_en      = r_dig;
  assign frame_pulse = r_fp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: vector table plus
// reset, en-drop and random scan corner cases.
module tb_seg_scan_driver;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] seg1_in;
  logic [6:0] seg2_in;
  logic [6:0] seg_out;
  logic [1:0] dig_en;
  logic       frame_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       fp;
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] dig;
    logic       fp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  seg_scan_driver #(
    .SHOW_CYCLES    (4),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .seg1_in     (seg1_in),
    .seg2_in     (seg2_in),
    .seg_out     (seg_out),
    .dig_en      (dig_en),
    .frame_pulse (frame_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(
    input int         n,
    input logic       e,
    input logic [6:0] s1,
    input logic [6:0] s2,
    input logic [6:0] sg,
    input logic [1:0] dg,
    input logic       fp
  );
    vec_t v;
    v.en = e; v.s1 = s1; v.s2 = s2;
    v.seg = sg; v.dig = dg; v.fp = fp;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic check(
    input string      nm,
    input logic [6:0] sg,
    input logic [1:0] dg,
    input logic       fp
  );
    n_chk++;
    if (seg_out !== sg || dig_en !== dg ||
        frame_pulse !== fp) begin
      n_fail++;
      $display(
        "FAIL %s: got seg=%h dig=%b fp=%b want seg=%h dig=%b fp=%b",
        nm, seg_out, dig_en, frame_pulse, sg, dg, fp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic step(
    input string      nm,
    input logic       e,
    input logic [6:0] s1,
    input logic [6:0] s2,
    input logic [6:0] sg,
    input logic [1:0] dg,
    input logic       fp
  );
    exp_t x;
    en = e; seg1_in = s1; seg2_in = s2;
    x.seg = sg; x.dig = dg; x.fp = fp;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      x = sb.pop_front();
      check(nm, x.seg, x.dig, x.fp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    seg1_in = '0; seg2_in = '0;

    // c1..c12 first frame, no frame pulse
    add(2, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 0);
    add(4, 1, 7'h3F, 7'h06, 7'h40, 2'b10, 0);
    add(2, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 0);
    add(4, 1, 7'h3F, 7'h06, 7'h79, 2'b01, 0);
    // c13..c24 second frame; seg1 changes in SHOW1
    add(1, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 1);
    add(1, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 0);
    add(4, 1, 7'h3F, 7'h06, 7'h40, 2'b10, 0);
    add(2, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 0);
    add(4, 1, 7'h5B, 7'h06, 7'h79, 2'b01, 0);
    // c25.. third frame shows the new sample
    add(1, 1, 7'h5B, 7'h06, 7'h7F, 2'b11, 1);
    add(1, 1, 7'h5B, 7'h06, 7'h7F, 2'b11, 0);
    add(2, 1, 7'h5B, 7'h06, 7'h24, 2'b10, 0);
    // en dropped mid-SHOW0, then restarted
    add(2, 0, 7'h5B, 7'h06, 7'h7F, 2'b11, 0);
    add(2, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 0);
    add(4, 1, 7'h3F, 7'h06, 7'h40, 2'b10, 0);
    add(2, 1, 7'h3F, 7'h06, 7'h7F, 2'b11, 0);
    add(1, 1, 7'h3F, 7'h06, 7'h79, 2'b01, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 7'h7F, 2'b11, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_en_low", 7'h7F, 2'b11, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].en,
           tbl[i].s1, tbl[i].s2, tbl[i].seg,
           tbl[i].dig, tbl[i].fp);
    end

    // Asynchronous reset in the middle of SHOW1
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 7'h7F, 2'b11, 1'b0);
    n_chk++;
    if (dut.r_snap0 !== 7'h00 ||
        dut.r_snap1 !== 7'h00) begin
      n_fail++;
      $display("FAIL async_rst_snap: got %h/%h want 00/00",
               dut.r_snap0, dut.r_snap1);
    end
    @(posedge clk);
    #1;
    check("rst_held", 7'h7F, 2'b11, 1'b0);
    rst_n = 1'b1;

    step("rr_b0a", 1, 7'h5B, 7'h3F, 7'h7F, 2'b11, 0);
    step("rr_b0b", 1, 7'h00, 7'h00, 7'h7F, 2'b11, 0);
    for (int i = 0; i < 4; i++)
      step("rr_s0", 1, 7'h00, 7'h00, 7'h24, 2'b10, 0);
    for (int i = 0; i < 2; i++)
      step("rr_b1", 1, 7'h00, 7'h00, 7'h7F, 2'b11, 0);
    for (int i = 0; i < 4; i++)
      step("rr_s1", 1, 7'h00, 7'h00, 7'h40, 2'b01, 0);
    step("rr_fp", 1, 7'h00, 7'h00, 7'h7F, 2'b11, 1);

    // Random scan: safety properties only
    for (int i = 0; i < 10000; i++) begin
      en      = ($urandom_range(0, 19) != 0);
      seg1_in = 7'($urandom);
      seg2_in = 7'($urandom);
      @(posedge clk);
      #1;
      n_chk++;
      if (dig_en === 2'b00) begin
        n_fail++;
        $display("FAIL rand_dig cyc%0d: got %b want not 00",
                 i, dig_en);
      end
      n_chk++;
      if (dig_en === 2'b11 && seg_out !== 7'h7F) begin
        n_fail++;
        $display("FAIL rand_seg cyc%0d: got %h want 7f",
                 i, seg_out);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 50000: clocks each digit is lit per frame (>=1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: all-off clocks before each digit (>=1), anti-ghosting.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit by driving 0.
REQ-004 SHALL have parameter DIG_ACTIVE_LOW, default 1: 1 = digit enabled by driving 0.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 en  input  1  scan enable; low blanks the display.
REQ-009 seg1_in  input  7  digit-0 pattern from the base-converter stage, active-high, bit order passed through unchanged.
REQ-010 seg2_in  input  7  digit-1 pattern, same convention.
REQ-011 seg_out  output  7  shared segment bus, polarity per SEG_ACTIVE_LOW.
REQ-012 dig_en  output  2  digit enables; bit0 = digit 0, bit1 = digit 1, polarity per DIG_ACTIVE_LOW.
REQ-013 frame_pulse  output  1  one-cycle strobe at each frame boundary.

Function
REQ-014 SHALL implement FSM states IDLE, BLANK0, SHOW0, BLANK1, SHOW1, plus one phase counter.
REQ-015 Transitions: IDLE->BLANK0 on en=1; BLANK0->SHOW0 after BLANK_CYCLES; SHOW0->BLANK1 after SHOW_CYCLES; BLANK1->SHOW1 after BLANK_CYCLES; SHOW1->BLANK0 after SHOW_CYCLES.
REQ-016 The phase counter SHALL clear on every state entry; a state is left on the edge where the counter equals its length-1.
REQ-017 en=0 sampled in any state SHALL force IDLE on that edge and clear the counter; en takes priority over phase expiry.
REQ-018 Snapshot registers snap0/snap1 SHALL load seg1_in/seg2_in together on every edge entering BLANK0 and hold otherwise, so both digits of a frame come from one sample (no tearing).
REQ-019 All outputs SHALL be registered and reflect the state being entered on the same edge (zero added latency).
REQ-020 IDLE, BLANK0, BLANK1: seg_out all segments off, dig_en both off.
REQ-021 SHOW0: seg_out = snap0, dig_en bit0 only on; SHOW1: seg_out = snap1, dig_en bit1 only on.
REQ-022 dig_en SHALL never have both bits on in any cycle.
REQ-023 frame_pulse SHALL be 1 for exactly the first BLANK0 cycle entered from SHOW1; not on entry from IDLE.
REQ-024 Frame length SHALL be 2*(BLANK_CYCLES+SHOW_CYCLES) clocks; counter width = clog2 of max(SHOW_CYCLES, BLANK_CYCLES), with no wrap beyond length-1.
REQ-025 Input changes mid-frame SHALL not affect seg_out until the next BLANK0 entry.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, snap0/snap1 = 0, seg_out all off, dig_en both off, frame_pulse 0.
REQ-027 Reset mid-frame SHALL abort the frame; after release, operation restarts from IDLE per REQ-015.

Structure
REQ-028 The state enum and the off/on polarity constants SHALL live in shared package seg_scan_pkg.
REQ-029 One sub-module, seg_phase_counter (load-clear, terminal-count compare), SHALL hold the counter; the FSM and output registers SHALL stay in the top module.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=2, both polarities active-low)
REQ-030 Reset release, en=1, seg1_in=7'h3F, seg2_in=7'h06 -> 2 cycles seg_out=7'h7F/dig_en=2'b11; 4 cycles seg_out=7'h40/dig_en=2'b10; 2 blank; 4 cycles seg_out=7'h79/dig_en=2'b01; frame 12 cycles.
REQ-031 Steady scan -> frame_pulse high once every 12 cycles, only on BLANK0 entry from SHOW1, never on the first frame.
REQ-032 Change seg1_in to 7'h5B during SHOW1 -> current frame unchanged; next SHOW0 shows 7'h24.
REQ-033 Drop en during SHOW0 -> next edge all off, IDLE; re-raise en -> 2 blank cycles, then SHOW0 with the fresh snapshot.
REQ-034 Assert rst_n=0 mid-SHOW1 asynchronously -> outputs off before the next clk edge; snapshots read 0.
REQ-035 Random en and inputs for 10k cycles -> assertion that dig_en never has both bits on, and seg_out is off whenever dig_en is off.
